// File: rtl/dram_access_ctrl.sv
// dram_access_ctrl: single-port data RAM load/store sequencer with saturating access counters; DRAM_BOUNDS_CHECK_EN enables an address bounds check
module dram_access_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic req_ready_q, req_ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic mem_write_en_q, mem_write_en_d, mem_read_en_q, mem_read_en_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d, resp_rdata_q, resp_rdata_d;
  logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;
  logic oob;
`ifdef DRAM_BOUNDS_CHECK_EN
  assign oob = {1'b0, req_addr} >= (ADDR_WIDTH+1)'(MEM_DEPTH);
`else
  assign oob = MEM_DEPTH < 0;
`endif
  // next-state and registered-output values; counters bump on entry to RESP
  always_comb begin
    state_d        = state_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_write_en_d = 1'b0;
    mem_read_en_d  = 1'b0;
    resp_valid_d   = 1'b0;
    resp_err_d     = 1'b0;
    resp_rdata_d   = resp_rdata_q;
    rd_count_d     = rd_count_q;
    wr_count_d     = wr_count_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (oob) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else begin
          state_d        = ISSUE;
          mem_addr_d     = req_addr;
          mem_wdata_d    = req_wdata;
          mem_write_en_d = req_write;
          mem_read_en_d  = !req_write;
        end
      end
      ISSUE: begin
        state_d      = mem_write_en_q ? RESP : WAIT;
        resp_valid_d = mem_write_en_q;
        wr_count_d   = wr_count_q + CNT_WIDTH'(mem_write_en_q && !(&wr_count_q));
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = mem_rdata;
        rd_count_d   = rd_count_q + CNT_WIDTH'(!(&rd_count_q));
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = state_d == IDLE;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      mem_write_en_q <= 1'b0;
      mem_read_en_q  <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      req_ready_q    <= req_ready_d;
      mem_write_en_q <= mem_write_en_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      resp_valid_q   <= resp_valid_d;
      resp_err_q     <= resp_err_d;
      resp_rdata_q   <= resp_rdata_d;
      rd_count_q     <= rd_count_d;
      wr_count_q     <= wr_count_d;
    end
  end
  assign req_ready    = req_ready_q;
  assign mem_write_en = mem_write_en_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign resp_valid   = resp_valid_q;
  assign resp_err     = resp_err_q;
  assign resp_rdata   = resp_rdata_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
endmodule

// File: tb/tb_dram_access_ctrl.sv
// tb_dram_access_ctrl: vector table, corner sequences and random traffic against a transaction-level model
module tb_dram_access_ctrl;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int CW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic req_ready, resp_valid, resp_err, mem_write_en, mem_read_en;
  logic [DW-1:0] resp_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] rd_count, wr_count;
  always #5 clk = ~clk;
  dram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rd_count(rd_count), .wr_count(wr_count)
  );
  typedef struct {
    logic wr; logic [AW-1:0] addr; logic [DW-1:0] data;
    int lat; logic [DW-1:0] rdata; logic err; int wr_n; int rd_n;
  } tvec_t;
  tvec_t tv [7];
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] m_ram [0:(1<<AW)-1];
  int age = -1, lat = 3, m_rd = 0, m_wr = 0;
  logic op_wr = 1'b0, op_oob = 1'b0;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_data = '0, m_rdata = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic oob_of(input logic [AW-1:0] a);
`ifdef DRAM_BOUNDS_CHECK_EN
    return a >= 32;
`else
    return a != a;
`endif
  endfunction
  // RAM: write at the strobe edge, read data registered one cycle after read_en
  initial begin
    foreach (ram[i]) begin ram[i] = '0; m_ram[i] = '0; end
    ram[1] = 16'd80; ram[2] = 16'd50; ram[40] = 16'h0a0a;
    m_ram[1] = 16'd80; m_ram[2] = 16'd50; m_ram[40] = 16'h0a0a;
    forever begin
      @(posedge clk);
      if (mem_read_en) mem_rdata <= ram[mem_addr];
      if (mem_write_en) ram[mem_addr] = mem_wdata;
    end
  end
  // transaction model: age counts edges since acceptance, response at age == latency
  initial forever begin
    @(posedge clk);
    if (rst) begin
      age = -1; m_rd = 0; m_wr = 0; m_rdata = '0;
    end else if (age == -1) begin
      if (req_valid) begin
        age = 1; op_wr = req_write; op_addr = req_addr; op_data = req_wdata; op_oob = oob_of(req_addr);
        lat = op_oob ? 1 : (op_wr ? 2 : 3);
        if (!op_oob && op_wr) m_ram[op_addr] = op_data;
      end
    end else age = (age == lat) ? -1 : age + 1;
    if (age == lat) begin
      if (op_oob) m_rdata = '0;
      else if (op_wr) m_wr = (m_wr == 65535) ? m_wr : m_wr + 1;
      else begin m_rdata = m_ram[op_addr]; m_rd = (m_rd == 65535) ? m_rd : m_rd + 1; end
    end
  end
  // per-cycle comparison of every output against the model
  initial begin
    logic ps, cs, st;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      st = age == 1 && !op_oob;
      chk("req_ready", req_ready, age == -1);
      chk("write_en", mem_write_en, st && op_wr);
      chk("read_en", mem_read_en, st && !op_wr);
      chk("resp_valid", resp_valid, age == lat);
      chk("resp_err", resp_err, age == lat && op_oob);
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("rd_count", rd_count, m_rd);
      chk("wr_count", wr_count, m_wr);
      chk("strobe_overlap", mem_write_en && mem_read_en, 0);
      cs = mem_write_en || mem_read_en;
      chk("strobe_gap", ps && cs, 0);
      ps = cs;
      if (st) chk("mem_addr", mem_addr, op_addr);
      if (st && op_wr) chk("mem_wdata", mem_wdata, op_data);
    end
  end
  task automatic do_req(input tvec_t v);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.data;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 8);
    chk("tv_latency", n, v.lat);
    chk("tv_rdata", resp_rdata, v.rdata);
    chk("tv_err", resp_err, v.err);
    chk("tv_wr_count", wr_count, v.wr_n);
    chk("tv_rd_count", rd_count, v.rd_n);
  endtask
  initial begin
    int last;
    logic acc, prev_wr;
    tv[0] = '{1'b1, 9'd5, 16'h1234, 2, 16'h0000, 1'b0, 1, 0};
    tv[1] = '{1'b0, 9'd5, 16'h0000, 3, 16'h1234, 1'b0, 1, 1};
    tv[2] = '{1'b0, 9'd1, 16'h0000, 3, 16'd80, 1'b0, 1, 2};
    tv[3] = '{1'b0, 9'd2, 16'h0000, 3, 16'd50, 1'b0, 1, 3};
    tv[4] = '{1'b1, 9'd7, 16'hbeef, 2, 16'd50, 1'b0, 2, 3};
    tv[5] = '{1'b0, 9'd7, 16'h0000, 3, 16'hbeef, 1'b0, 2, 4};
`ifdef DRAM_BOUNDS_CHECK_EN
    tv[6] = '{1'b0, 9'd40, 16'h0000, 1, 16'h0000, 1'b1, 2, 4};
`else
    tv[6] = '{1'b0, 9'd40, 16'h0000, 3, 16'h0a0a, 1'b0, 2, 5};
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_outs", {mem_write_en, mem_read_en, resp_valid, resp_err, mem_addr, mem_wdata}, 0);
    chk("rst_rdata_cnt", {resp_rdata, rd_count}, 0);
    chk("rst_wr_count", wr_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    foreach (tv[i]) do_req(tv[i]);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'd10; req_wdata = 16'h5a5a;
    last = -1; prev_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      acc = req_ready;
      if (acc) begin
        if (last >= 0) chk("busy_spacing", i - last, prev_wr ? 3 : 4);
        last = i; prev_wr = req_write;
      end
      @(posedge clk);
      #1 if (acc) req_write = ~req_write;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'd5;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_resp", resp_valid, 0);
    chk("midrst_idle", req_ready, 1);
    do_req('{1'b0, 9'd5, 16'h0000, 3, 16'h1234, 1'b0, 0, 1});
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = 1'($urandom);
      req_write = 1'($urandom);
`ifdef DRAM_BOUNDS_CHECK_EN
      req_addr = AW'($urandom_range(0, 63));
`else
      req_addr = AW'($urandom_range(0, 31));
`endif
      req_wdata = DW'($urandom);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
